// File: rtl/s2p_lane_rx_align.sv
// s2p_lane_rx_align
//   Single-lane serial-to-parallel receiver with COM-symbol byte alignment.
//   Serial bits arrive MSB first on the bit clock. The block hunts for COM at
//   every bit offset. It locks after COM_REQ consecutive COMs on byte
//   boundaries. It then delivers each boundary byte on OUT_DATA with a
//   one-cycle strobe: OUT_VALID marks a data byte and OUT_COM marks an idle COM.
//
// Ports
//   IN_CLK      bit clock, all logic on the rising edge
//   IN_RESET    synchronous active-high reset, has priority over IN_ENB
//   IN_ENB      enable; when low every register holds
//   IN_SERIAL   serial data bit, MSB of each byte first
//   OUT_DATA    last byte received on a boundary while aligned
//   OUT_VALID   1-cycle pulse: OUT_DATA holds a data (non-COM) byte
//   OUT_COM     1-cycle pulse: a COM byte arrived on a boundary while aligned
//   OUT_ALIGNED high while in the ALIGNED state
module s2p_lane_rx_align #(
    parameter logic [7:0]  COM     = 8'hBC,
    parameter int unsigned COM_REQ = 4
) (
    input  logic       IN_CLK,
    input  logic       IN_RESET,
    input  logic       IN_ENB,
    input  logic       IN_SERIAL,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    output logic       OUT_COM,
    output logic       OUT_ALIGNED
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ALIGNED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LAST = 4'(COM_REQ - 1);

    state_t     state, state_nxt;
    logic [7:0] sr, sr_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [3:0] com_cnt, com_cnt_nxt;
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic       com_nxt;
    logic       match;
    logic       boundary;

    // The compare uses the register contents before this edge's shift, so
    // the byte that is checked is the one completed on the previous edge.
    assign match    = (sr == COM);
    assign boundary = (state != SEARCH) && (bit_cnt == 3'd0);

    // State and datapath registers
    always_ff @(posedge IN_CLK) begin
        if (IN_RESET) begin
            state     <= SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            OUT_COM   <= 1'b0;
        end else if (IN_ENB) begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            bit_cnt   <= bit_cnt_nxt;
            com_cnt   <= com_cnt_nxt;
            OUT_DATA  <= data_nxt;
            OUT_VALID <= valid_nxt;
            OUT_COM   <= com_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        sr_nxt      = {sr[6:0], IN_SERIAL};
        bit_cnt_nxt = bit_cnt;
        com_cnt_nxt = com_cnt;
        unique case (state)
            SEARCH: begin
                // The COM seen now ended on the previous edge, so this edge
                // is already bit 1 of the next byte.
                if (match) begin
                    state_nxt   = LOCKING;
                    bit_cnt_nxt = 3'd1;
                    com_cnt_nxt = 4'd1;
                end
            end
            LOCKING: begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (boundary) begin
                    if (match && (com_cnt == LOCK_LAST)) begin
                        state_nxt   = ALIGNED;
                        com_cnt_nxt = '0;
                    end else if (match) begin
                        com_cnt_nxt = com_cnt + 4'd1;
                    end else begin
                        state_nxt   = SEARCH;
                        com_cnt_nxt = '0;
                        bit_cnt_nxt = '0;
                    end
                end
            end
            ALIGNED: begin
                bit_cnt_nxt = bit_cnt + 3'd1;
            end
            default: begin
                state_nxt   = SEARCH;
                bit_cnt_nxt = '0;
                com_cnt_nxt = '0;
            end
        endcase
    end

    // Output logic: boundary bytes are captured only while aligned
    always_comb begin
        data_nxt    = OUT_DATA;
        valid_nxt   = 1'b0;
        com_nxt     = 1'b0;
        OUT_ALIGNED = (state == ALIGNED);
        if ((state == ALIGNED) && boundary) begin
            data_nxt  = sr;
            valid_nxt = !match;
            com_nxt   = match;
        end
    end

endmodule

// File: tb/tb_s2p_lane_rx_align.sv
module tb_s2p_lane_rx_align;

    logic       IN_CLK = 1'b0;
    logic       IN_RESET = 1'b1;
    logic       IN_ENB = 1'b1;
    logic       IN_SERIAL = 1'b0;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_COM;
    logic       OUT_ALIGNED;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // Outputs observed 1 time unit after each numbered rising edge
    logic [7:0] obs_data[256];
    logic       obs_valid[256];
    logic       obs_com[256];
    logic       obs_aligned[256];

    always #5 IN_CLK = ~IN_CLK;

    s2p_lane_rx_align #(
        .COM     (8'hBC),
        .COM_REQ (4)
    ) dut (
        .IN_CLK      (IN_CLK),
        .IN_RESET    (IN_RESET),
        .IN_ENB      (IN_ENB),
        .IN_SERIAL   (IN_SERIAL),
        .OUT_DATA    (OUT_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_COM     (OUT_COM),
        .OUT_ALIGNED (OUT_ALIGNED)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic b);
        IN_SERIAL = b;
        @(posedge IN_CLK);
        #1;
        edge_n++;
        if (edge_n < 256) begin
            obs_data[edge_n]    = OUT_DATA;
            obs_valid[edge_n]   = OUT_VALID;
            obs_com[edge_n]     = OUT_COM;
            obs_aligned[edge_n] = OUT_ALIGNED;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(b[i]);
    endtask

    task automatic do_reset;
        IN_ENB    = 1'b1;
        IN_RESET  = 1'b1;
        IN_SERIAL = 1'b0;
        @(posedge IN_CLK);
        #1;
        IN_RESET = 1'b0;
        edge_n   = 0;
    endtask

    // Reset, three idle zeros, four COMs: aligned after edge 36,
    // first data byte on edges 36..43, its strobe after edge 44.
    task automatic lock_up;
        do_reset();
        repeat (3) tick(1'b0);
        repeat (4) send_byte(8'hBC);
    endtask

    task automatic test_reset;
        IN_RESET = 1'b1;
        IN_ENB   = 1'b0;
        repeat (2) @(posedge IN_CLK);
        #1;
        checks++; if (OUT_DATA !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", OUT_DATA); end
        checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", OUT_VALID); end
        checks++; if (OUT_COM !== 1'b0) begin failures++; $display("FAIL reset_com: got %b want 0", OUT_COM); end
        checks++; if (OUT_ALIGNED !== 1'b0) begin failures++; $display("FAIL reset_aligned: got %b want 0", OUT_ALIGNED); end
        IN_RESET = 1'b0;
        IN_ENB   = 1'b1;
    endtask

    task automatic test_lock;
        lock_up();
        send_byte(8'h5A);
        tick(1'b0);
        tick(1'b0);
        for (int e = 1; e <= 45; e++) begin
            checks++;
            if (obs_aligned[e] !== (e >= 36)) begin failures++; $display("FAIL lock_aligned edge %0d: got %b want %b", e, obs_aligned[e], (e >= 36)); end
            checks++;
            if (obs_valid[e] !== (e == 44)) begin failures++; $display("FAIL lock_valid edge %0d: got %b want %b", e, obs_valid[e], (e == 44)); end
            checks++;
            if (obs_com[e] !== 1'b0) begin failures++; $display("FAIL lock_com edge %0d: got %b want 0", e, obs_com[e]); end
        end
        checks++; if (obs_data[43] !== 8'h00) begin failures++; $display("FAIL lock_data_pre: got %h want 00", obs_data[43]); end
        checks++; if (obs_data[44] !== 8'h5A) begin failures++; $display("FAIL lock_data: got %h want 5a", obs_data[44]); end
        checks++; if (obs_data[45] !== 8'h5A) begin failures++; $display("FAIL lock_data_hold: got %h want 5a", obs_data[45]); end
    endtask

    task automatic test_data_mix;
        logic [7:0] mix[4];
        logic       mix_v[4];
        logic [7:0] exp_data;
        logic       exp_v, exp_c;
        int         k;
        mix   = '{8'h11, 8'hBC, 8'hFF, 8'h00};
        mix_v = '{1'b1, 1'b0, 1'b1, 1'b1};
        lock_up();
        for (int i = 0; i < 4; i++) send_byte(mix[i]);
        tick(1'b0);
        exp_data = 8'h00;
        for (int e = 36; e <= 68; e++) begin
            exp_v = 1'b0;
            exp_c = 1'b0;
            if (e >= 44 && ((e - 44) % 8) == 0) begin
                k        = (e - 44) / 8;
                exp_v    = mix_v[k];
                exp_c    = !mix_v[k];
                exp_data = mix[k];
            end
            checks++;
            if (obs_valid[e] !== exp_v) begin failures++; $display("FAIL mix_valid edge %0d: got %b want %b", e, obs_valid[e], exp_v); end
            checks++;
            if (obs_com[e] !== exp_c) begin failures++; $display("FAIL mix_com edge %0d: got %b want %b", e, obs_com[e], exp_c); end
            checks++;
            if (obs_data[e] !== exp_data) begin failures++; $display("FAIL mix_data edge %0d: got %h want %h", e, obs_data[e], exp_data); end
            checks++;
            if (obs_aligned[e] !== 1'b1) begin failures++; $display("FAIL mix_aligned edge %0d: got %b want 1", e, obs_aligned[e]); end
        end
    endtask

    task automatic test_enable_stall;
        logic       exp_v;
        logic [7:0] exp_data;
        lock_up();
        tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);   // edges 36..39
        IN_ENB = 1'b0;
        repeat (5) tick(1'b1);                            // edges 40..44, ignored
        IN_ENB = 1'b1;
        tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);   // edges 45..48
        tick(1'b0);                                       // edge 49: strobe
        IN_ENB = 1'b0;
        tick(1'b0); tick(1'b0);                           // edges 50,51: strobe held
        IN_ENB = 1'b1;
        tick(1'b0);                                       // edge 52
        for (int e = 36; e <= 52; e++) begin
            exp_v    = (e >= 49 && e <= 51);
            exp_data = (e >= 49) ? 8'hA5 : 8'h00;
            checks++;
            if (obs_valid[e] !== exp_v) begin failures++; $display("FAIL stall_valid edge %0d: got %b want %b", e, obs_valid[e], exp_v); end
            checks++;
            if (obs_com[e] !== 1'b0) begin failures++; $display("FAIL stall_com edge %0d: got %b want 0", e, obs_com[e]); end
            checks++;
            if (obs_data[e] !== exp_data) begin failures++; $display("FAIL stall_data edge %0d: got %h want %h", e, obs_data[e], exp_data); end
            checks++;
            if (obs_aligned[e] !== 1'b1) begin failures++; $display("FAIL stall_aligned edge %0d: got %b want 1", e, obs_aligned[e]); end
        end
    endtask

    task automatic test_lock_abort;
        do_reset();
        repeat (3) tick(1'b0);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h3C);
        repeat (4) send_byte(8'hBC);
        send_byte(8'h00);
        tick(1'b0);
        for (int e = 1; e <= 68; e++) begin
            checks++;
            if (obs_aligned[e] !== (e >= 60)) begin failures++; $display("FAIL abort_aligned edge %0d: got %b want %b", e, obs_aligned[e], (e >= 60)); end
            checks++;
            if (obs_valid[e] !== (e == 68)) begin failures++; $display("FAIL abort_valid edge %0d: got %b want %b", e, obs_valid[e], (e == 68)); end
            checks++;
            if (obs_com[e] !== 1'b0) begin failures++; $display("FAIL abort_com edge %0d: got %b want 0", e, obs_com[e]); end
        end
    endtask

    task automatic test_reset_mid;
        lock_up();
        send_byte(8'h77);                 // edges 36..43
        tick(1'b1); tick(1'b1); tick(1'b1); // edges 44..46, mid-byte
        IN_RESET = 1'b1;
        IN_ENB   = 1'b0;
        tick(1'b0);                       // edge 47: reset wins over disable
        checks++; if (obs_valid[44] !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid: got %b want 1", obs_valid[44]); end
        checks++; if (obs_data[46] !== 8'h77) begin failures++; $display("FAIL rmid_pre_data: got %h want 77", obs_data[46]); end
        checks++; if (obs_aligned[46] !== 1'b1) begin failures++; $display("FAIL rmid_pre_aligned: got %b want 1", obs_aligned[46]); end
        checks++; if (obs_data[47] !== 8'h00) begin failures++; $display("FAIL rmid_data: got %h want 00", obs_data[47]); end
        checks++; if (obs_valid[47] !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b want 0", obs_valid[47]); end
        checks++; if (obs_com[47] !== 1'b0) begin failures++; $display("FAIL rmid_com: got %b want 0", obs_com[47]); end
        checks++; if (obs_aligned[47] !== 1'b0) begin failures++; $display("FAIL rmid_aligned: got %b want 0", obs_aligned[47]); end
        IN_RESET = 1'b0;
        IN_ENB   = 1'b1;
        edge_n   = 0;
        // Three COMs are one short of lock; the following 00 drops back to hunting.
        repeat (3) send_byte(8'hBC);      // edges 1..24
        send_byte(8'h00);                 // edges 25..32
        repeat (4) send_byte(8'hBC);      // edges 33..64
        tick(1'b0);                       // edge 65
        for (int e = 1; e <= 65; e++) begin
            checks++;
            if (obs_aligned[e] !== (e == 65)) begin failures++; $display("FAIL relock_aligned edge %0d: got %b want %b", e, obs_aligned[e], (e == 65)); end
            checks++;
            if (obs_valid[e] !== 1'b0 || obs_com[e] !== 1'b0) begin failures++; $display("FAIL relock_strobe edge %0d: got v=%b c=%b want v=0 c=0", e, obs_valid[e], obs_com[e]); end
        end
    endtask

    task automatic test_false_com;
        logic [7:0] exp_data;
        lock_up();
        send_byte(8'h0B);
        send_byte(8'hC0);
        tick(1'b0);
        for (int e = 36; e <= 52; e++) begin
            exp_data = (e >= 52) ? 8'hC0 : ((e >= 44) ? 8'h0B : 8'h00);
            checks++;
            if (obs_valid[e] !== (e == 44 || e == 52)) begin failures++; $display("FAIL fcom_valid edge %0d: got %b want %b", e, obs_valid[e], (e == 44 || e == 52)); end
            checks++;
            if (obs_com[e] !== 1'b0) begin failures++; $display("FAIL fcom_com edge %0d: got %b want 0", e, obs_com[e]); end
            checks++;
            if (obs_data[e] !== exp_data) begin failures++; $display("FAIL fcom_data edge %0d: got %h want %h", e, obs_data[e], exp_data); end
            checks++;
            if (obs_aligned[e] !== 1'b1) begin failures++; $display("FAIL fcom_aligned edge %0d: got %b want 1", e, obs_aligned[e]); end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_data_mix();
        test_enable_stall();
        test_lock_abort();
        test_reset_mid();
        test_false_com();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
